// File: rtl/fft_fp_pkg.sv
// ---------------------------------------------------------------------------
// fft_fp_pkg: IEEE-754 single-precision types shared by the FFT int/float paths.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fft_fp_pkg;

  localparam int FP_EXP_W  = 8;
  localparam int FP_MANT_W = 23;
  localparam int FP_BIAS   = 127;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_MANT_W-1:0] frac;
  } fp32_t;

  typedef enum logic [1:0] {
    FP_ZERO,
    FP_NORM,
    FP_INF,
    FP_NAN
  } fp_class_t;

  // Denormals classify as FP_ZERO; the caller tracks a nonzero fraction separately.
  function automatic fp_class_t fp_classify(input fp32_t f);
    if (f.exp == '1) return (f.frac != '0) ? FP_NAN : FP_INF;
    if (f.exp == '0) return FP_ZERO;
    return FP_NORM;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fft_fp2int_shifter.sv
// ---------------------------------------------------------------------------
// fft_fp2int_shifter: bidirectional barrel shifter returning magnitude, guard, sticky.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fft_fp2int_shifter
  import fft_fp_pkg::*;
#(
  parameter int OUT_W = 32
) (
  input  logic [FP_MANT_W:0]  mant,
  input  logic signed [9:0]   sh,
  output logic [OUT_W-1:0]    mag,
  output logic                guard,
  output logic                sticky,
  output logic                big
);

  localparam int MW = FP_MANT_W + 1;
  localparam int EW = 2 * MW + 2;

  logic [OUT_W-1:0] mant_ext;
  logic [EW-1:0]    rext;
  logic [9:0]       rsh;

  // Right shifts go through a window holding the integer part, a guard bit and
  // MW sticky positions, enough for shift distances up to MW+1.
  always_comb begin
    mant_ext = OUT_W'(mant);
    rsh      = 10'(-sh);
    rext     = {mant, {(MW + 2){1'b0}}} >> rsh;
    mag      = '0;
    guard    = 1'b0;
    sticky   = 1'b0;
    big      = 1'b0;
    if (!sh[9]) begin
      // A shift of exactly OUT_W-MW can still be -2^(OUT_W-1); the final call is made downstream.
      if ($unsigned(sh) > 10'(OUT_W - MW)) big = 1'b1;
      else mag = mant_ext << $unsigned(sh);
    end else if (rsh > 10'(MW + 1)) begin
      sticky = 1'b1;
    end else begin
      mag    = OUT_W'(rext[EW-1 -: MW]);
      guard  = rext[MW+1];
      sticky = |rext[MW:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/fft_fp2int_unit.sv
// ---------------------------------------------------------------------------
// fft_fp2int_unit: 3-stage IEEE-754 single to saturating signed fixed-point converter.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fft_fp2int_unit
  import fft_fp_pkg::*;
#(
  parameter int OUT_W      = 32,
  parameter int FRAC_BITS  = 0,
  parameter int ROUND_MODE = 1
) (
  input  logic             s_axi_aclk,
  input  logic             s_axi_aresetn,
  input  logic [31:0]      fp_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] int_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_ovf,
  output logic             out_nan,
  output logic             out_inexact
);

  localparam int                SUM_W   = OUT_W + 1;
  localparam logic signed [9:0] SH_OFS  = 10'(FRAC_BITS - FP_BIAS - FP_MANT_W);
  localparam logic [SUM_W-1:0]  POS_LIM = {2'b00, {(OUT_W - 1){1'b1}}};
  localparam logic [SUM_W-1:0]  NEG_LIM = {2'b01, {(OUT_W - 1){1'b0}}};
  localparam logic [OUT_W-1:0]  POS_SAT = {1'b0, {(OUT_W - 1){1'b1}}};
  localparam logic [OUT_W-1:0]  NEG_SAT = {1'b1, {(OUT_W - 1){1'b0}}};

  fp32_t             fp_in;
  logic signed [9:0] sh_in;
  logic              adv;
  logic              rst_done;

  logic              s1_valid, s1_sign, s1_denorm;
  fp_class_t         s1_cls;
  logic [FP_MANT_W:0] s1_mant;
  logic signed [9:0] s1_sh;

  logic              s2_valid, s2_sign, s2_denorm;
  fp_class_t         s2_cls;
  logic [OUT_W-1:0]  s2_mag;
  logic              s2_guard, s2_sticky, s2_big;

  logic [OUT_W-1:0]  sh_mag;
  logic              sh_guard, sh_sticky, sh_big;

  logic              rnd_up, over;
  logic [SUM_W-1:0]  rnd_sum;
  logic [OUT_W-1:0]  res;
  logic              res_ovf, res_nan, res_inx;

  assign fp_in    = fp_data;
  assign sh_in    = $signed({2'b00, fp_in.exp}) + SH_OFS;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv & rst_done;

  fft_fp2int_shifter #(.OUT_W(OUT_W)) u_shifter (
    .mant   (s1_mant),
    .sh     (s1_sh),
    .mag    (sh_mag),
    .guard  (sh_guard),
    .sticky (sh_sticky),
    .big    (sh_big)
  );

  always_comb begin
    rnd_up  = (ROUND_MODE == 1) && s2_guard && (s2_sticky || s2_mag[0]);
    rnd_sum = {1'b0, s2_mag} + SUM_W'(rnd_up);
    over    = s2_big || (s2_sign ? (rnd_sum > NEG_LIM) : (rnd_sum > POS_LIM));
    res     = '0;
    res_ovf = 1'b0;
    res_nan = 1'b0;
    res_inx = 1'b0;
    case (s2_cls)
      FP_NAN:  res_nan = 1'b1;
      FP_INF: begin
        res     = s2_sign ? NEG_SAT : POS_SAT;
        res_ovf = 1'b1;
      end
      FP_ZERO: res_inx = s2_denorm;
      default: begin
        res_inx = s2_guard | s2_sticky;
        if (over) begin
          res     = s2_sign ? NEG_SAT : POS_SAT;
          res_ovf = 1'b1;
        end else begin
          // Negating a zero magnitude yields 0, so -0 cannot appear.
          res = s2_sign ? -rnd_sum[OUT_W-1:0] : rnd_sum[OUT_W-1:0];
        end
      end
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      rst_done    <= 1'b0;
      s1_valid    <= 1'b0;
      s1_sign     <= 1'b0;
      s1_denorm   <= 1'b0;
      s1_cls      <= FP_ZERO;
      s1_mant     <= '0;
      s1_sh       <= '0;
      s2_valid    <= 1'b0;
      s2_sign     <= 1'b0;
      s2_denorm   <= 1'b0;
      s2_cls      <= FP_ZERO;
      s2_mag      <= '0;
      s2_guard    <= 1'b0;
      s2_sticky   <= 1'b0;
      s2_big      <= 1'b0;
      out_valid   <= 1'b0;
      int_data    <= '0;
      out_ovf     <= 1'b0;
      out_nan     <= 1'b0;
      out_inexact <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      if (adv) begin
        s1_valid    <= in_valid & in_ready;
        s1_sign     <= fp_in.sign;
        s1_denorm   <= (fp_in.exp == '0) && (fp_in.frac != '0);
        s1_cls      <= fp_classify(fp_in);
        s1_mant     <= {1'b1, fp_in.frac};
        s1_sh       <= sh_in;
        s2_valid    <= s1_valid;
        s2_sign     <= s1_sign;
        s2_denorm   <= s1_denorm;
        s2_cls      <= s1_cls;
        s2_mag      <= sh_mag;
        s2_guard    <= sh_guard;
        s2_sticky   <= sh_sticky;
        s2_big      <= sh_big;
        out_valid   <= s2_valid;
        int_data    <= res;
        out_ovf     <= res_ovf;
        out_nan     <= res_nan;
        out_inexact <= res_inx;
      end
    end
  end

endmodule

`default_nettype wire
